// File: rtl/axis_packet_arbiter.sv
// Purpose: packet-granular round-robin arbiter sharing one AXI-Stream master among NUM_SRC sources.
// Latency: one IDLE arbitration cycle per packet, then zero-latency combinational beat pass-through.
// Backpressure: m_tready is routed only to the grantee's s_tready; all other sources see 0.
// Optional: define AXIS_ARB_TRUNCATE_EN to force tlast on beat MAX_PKT_LEN and raise sticky err_trunc.
module axis_packet_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SRC     = 4,
  parameter int MAX_PKT_LEN = 256
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic [NUM_SRC-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic [$clog2(NUM_SRC)-1:0]    grant_id,
  output logic                          busy,
  output logic [15:0]                   pkt_count,
  output logic                          err_trunc
);

  localparam int GW = $clog2(NUM_SRC);

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_grant_id, r_last_grant;
  logic [GW-1:0] w_rr_pick, w_rr_cand;
  logic          w_rr_found;
  logic [15:0]   r_pkt_count;
  logic          w_src_last, w_force_last, w_hs, w_pkt_end;

  assign w_src_last = s_tlast[r_grant_id];

  // Round-robin search starting one past the previous grantee, wrapping at NUM_SRC.
  always_comb begin
    w_rr_pick  = r_grant_id;
    w_rr_found = 1'b0;
    w_rr_cand  = r_last_grant;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_rr_cand = (w_rr_cand == GW'(NUM_SRC - 1)) ? '0 : w_rr_cand + GW'(1);
      if (!w_rr_found && s_tvalid[w_rr_cand]) begin
        w_rr_found = 1'b1;
        w_rr_pick  = w_rr_cand;
      end
    end
  end

  // Next-state and datapath muxing; IDLE blocks every source, XFER passes the grantee through.
  always_comb begin
    w_state_nxt = r_state;
    m_tdata     = s_tdata[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    s_tready    = '0;
    w_hs        = 1'b0;
    w_pkt_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rr_found) w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        m_tvalid             = s_tvalid[r_grant_id];
        m_tlast              = w_src_last | w_force_last;
        s_tready[r_grant_id] = m_tready;
        w_hs                 = m_tvalid & m_tready;
        w_pkt_end            = w_hs & m_tlast;
        if (w_pkt_end) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; a reset mid-packet simply abandons the transfer.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Grant capture, fairness pointer and completed-packet counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_grant_id   <= '0;
      r_last_grant <= GW'(NUM_SRC - 1);
      r_pkt_count  <= 16'd0;
    end else begin
      if (r_state == ST_IDLE && w_rr_found) r_grant_id <= w_rr_pick;
      if (w_pkt_end) begin
        r_last_grant <= r_grant_id;
        r_pkt_count  <= r_pkt_count + 16'd1;
      end
    end
  end

`ifdef AXIS_ARB_TRUNCATE_EN
  localparam int CW = $clog2(MAX_PKT_LEN + 1);

  logic [CW-1:0] r_beat_cnt;
  logic          r_err_trunc;

  assign w_force_last = (r_state == ST_XFER) && (r_beat_cnt == CW'(MAX_PKT_LEN - 1)) && !w_src_last;
  assign err_trunc    = r_err_trunc;

  // Beat counter cleared on each grant; sticky flag records any forced packet end.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_beat_cnt  <= '0;
      r_err_trunc <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_rr_found) r_beat_cnt <= '0;
      else if (w_hs)                        r_beat_cnt <= r_beat_cnt + CW'(1);
      if (w_hs && w_force_last)             r_err_trunc <= 1'b1;
    end
  end
`else
  assign w_force_last = 1'b0;
  assign err_trunc    = 1'b0;
`endif

  assign grant_id  = r_grant_id;
  assign busy      = (r_state == ST_XFER);
  assign pkt_count = r_pkt_count;

endmodule
